// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external dual-port memory macro.
// Optional sticky overflow/underflow flags are built in when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_ctrl #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = (1 << ASIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow,
`endif
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic [ASIZE:0]   level,
    output logic             mem_wen,
    output logic [ASIZE-1:0] mem_waddr,
    output logic [DSIZE-1:0] mem_wdata,
    output logic [ASIZE-1:0] mem_raddr,
    input  logic [DSIZE-1:0] mem_rdata
);

    localparam logic [ASIZE:0] AF_TH = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_TH = (ASIZE+1)'(AE_LEVEL);
    localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic           push_ok;
    logic           pop_ok;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    always_comb begin
        empty        = (wptr == rptr);
        full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                       (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
        level        = wptr - rptr;
        almost_full  = (level >= AF_TH);
        almost_empty = (level <= AE_TH);
        push_ok      = wr_en & ~full & ~rst;
        pop_ok       = rd_en & ~empty & ~rst;
        mem_wen      = push_ok;
        mem_waddr    = wptr[ASIZE-1:0];
        mem_wdata    = wr_data;
        mem_raddr    = rptr[ASIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + PTR_ONE;
            if (pop_ok) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem_rdata;
            end
            rd_valid <= pop_ok;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A new error in the same cycle takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rd_en & empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench for fifo_sync_ctrl with a behavioural memory macro.
// Error-flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] level;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;
`ifdef FIFO_ERR_FLAGS_EN
    logic       err_clr;
    logic       overflow;
    logic       underflow;
`endif

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_wen)
            mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    fifo_sync_ctrl #(.DSIZE(8), .ASIZE(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(err_clr),
        .overflow(overflow),
        .underflow(underflow),
`endif
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .almost_full(almost_full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .almost_empty(almost_empty),
        .level(level),
        .mem_wen(mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        tick(); tick();
        wr_en = 1'b1; wr_data = 8'h99;
        #1;
        check("rst_mem_wen", mem_wen, 0);
        tick();
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            #1;
            check("fill_wen", mem_wen, 1);
            check("fill_waddr", mem_waddr, i);
            tick();
            check("fill_level", level, i + 1);
            check("fill_ae", almost_empty, (i + 1) <= 2);
            check("fill_af", almost_full, (i + 1) >= 14);
        end
        wr_en = 1'b0;
        check("fill_full", full, 1);

        // overflow attempt
        wr_en = 1'b1; wr_data = 8'hAA;
        #1;
        check("ovf_wen", mem_wen, 0);
        tick();
        wr_en = 1'b0;
        check("ovf_level", level, 16);
        check("ovf_full", full, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", overflow, 1);
        tick();
        check("ovf_sticky", overflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", overflow, 0);
`endif

        // drain in order, overflow data must not appear
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, i);
            check("drain_level", level, 15 - i);
            check("drain_af", almost_full, (15 - i) >= 14);
        end
        rd_en = 1'b0;
        tick();
        check("drain_valid_off", rd_valid, 0);
        check("drain_hold", rd_data, 8'h0F);
        check("drain_empty", empty, 1);

        // underflow attempt
        rd_en = 1'b1;
        tick();
        check("unf_valid", rd_valid, 0);
        check("unf_raddr", mem_raddr, 0);
        check("unf_level", level, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf_flag", underflow, 1);
        err_clr = 1'b1;
        tick();
        check("unf_set_wins", underflow, 1);
        rd_en = 1'b0;
        tick();
        err_clr = 1'b0;
        check("unf_clr", underflow, 0);
`endif
        rd_en = 1'b0;

        // push+pop while empty: push only, no bypass
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        tick();
        exp_q.push_back(8'h55);
        rd_en = 1'b0;
        check("emp_both_valid", rd_valid, 0);
        check("emp_both_level", level, 1);
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h56 + 8'(i);
            tick();
            exp_q.push_back(wr_data);
        end
        wr_en = 1'b0;
        check("conc_start_level", level, 5);

        // concurrent push/pop at level 5
        wr_en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'h60 + 8'(i);
            tick();
            exp_q.push_back(wr_data);
            d = exp_q.pop_front();
            check("conc_valid", rd_valid, 1);
            check("conc_data", rd_data, d);
            check("conc_level", level, 5);
        end
        rd_en = 1'b0;

        // top up to full
        for (int i = 0; i < 11; i++) begin
            wr_data = 8'hB0 + 8'(i);
            tick();
            exp_q.push_back(wr_data);
        end
        check("refill_full", full, 1);

        // push+pop while full: pop only
        rd_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        d = exp_q.pop_front();
        check("full_both_valid", rd_valid, 1);
        check("full_both_data", rd_data, d);
        check("full_both_level", level, 15);

        for (int i = 0; i < 6; i++) begin
            tick();
            d = exp_q.pop_front();
            check("pre_rst_data", rd_data, d);
        end
        check("pre_rst_level", level, 9);

        // reset mid-transfer
        wr_en = 1'b1; rd_en = 1'b1; rst = 1'b1; wr_data = 8'h77;
        #1;
        check("mid_rst_wen", mem_wen, 0);
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_valid", rd_valid, 1);
        check("post_rst_data", rd_data, 8'hC3);
        check("post_rst_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
